// File: rtl/frame_fetcher.sv
// Frame fetcher: streams FRAME_WORDS words from RAM port B, starting at a latched base,
// through a small credit-controlled FIFO onto a valid/ready output.
module frame_fetcher #(
  parameter int FRAME_WORDS = 1200,
  parameter int FIFO_DEPTH  = 8,
  parameter int RD_LATENCY  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] base_addr,
  output logic [15:0] addr_B,
  input  logic [15:0] out_B,
  output logic [15:0] word_data,
  output logic        word_valid,
  input  logic        word_ready,
  output logic        word_last,
  output logic        busy,
  output logic        frame_done
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [15:0] FW_M1   = 16'(FRAME_WORDS - 1);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0] CNT_ONE = (AW+1)'(1);

  if (RD_LATENCY != 1 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
    $error("frame_fetcher: unsupported parameter set");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t        r_state;
  logic [15:0]   r_base;
  logic [15:0]   r_issue_cnt;
  logic [15:0]   r_cap_cnt;
  logic          r_inflight;
  logic [15:0]   r_addr;
  logic          r_busy;
  logic          r_frame_done;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic [15:0]   r_mem [FIFO_DEPTH];
  logic          r_tag [FIFO_DEPTH];

  logic w_push;
  logic w_pop;
  logic w_credit;
  logic w_cap_last;
  logic w_head_last;

  // The inflight read still owns a FIFO slot, so it counts against the credit.
  assign w_push      = r_inflight;
  assign w_pop       = (r_count != '0) && word_ready;
  assign w_credit    = (r_count + ((AW+1)'(r_inflight))) < DEPTH_C;
  assign w_cap_last  = (r_cap_cnt == FW_M1);
  assign w_head_last = r_tag[r_rd_ptr];

  assign addr_B     = r_addr;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;
  assign word_valid = (r_count != '0);
  assign word_data  = r_mem[r_rd_ptr];
  assign word_last  = word_valid && w_head_last;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= out_B;
      r_tag[r_wr_ptr] <= w_cap_last;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_base       <= 16'h0000;
      r_issue_cnt  <= 16'h0000;
      r_cap_cnt    <= 16'h0000;
      r_inflight   <= 1'b0;
      r_addr       <= 16'h0000;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
    end else begin
      r_frame_done <= 1'b0;
      if (w_push) begin
        r_wr_ptr  <= r_wr_ptr + PTR_ONE;
        r_cap_cnt <= r_cap_cnt + 16'd1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
      case (r_state)
        S_IDLE: begin
          r_inflight <= 1'b0;
          if (start) begin
            r_base      <= base_addr;
            r_issue_cnt <= 16'h0000;
            r_cap_cnt   <= 16'h0000;
            r_busy      <= 1'b1;
            r_state     <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (w_credit) begin
            r_addr      <= r_base + r_issue_cnt;
            r_issue_cnt <= r_issue_cnt + 16'd1;
            r_inflight  <= 1'b1;
            if (r_issue_cnt == FW_M1) begin
              r_state <= S_DRAIN;
            end
          end else begin
            r_inflight <= 1'b0;
          end
        end
        S_DRAIN: begin
          r_inflight <= 1'b0;
          // The last-tagged word leaving means the FIFO and read pipe are both empty.
          if (w_pop && w_head_last) begin
            r_frame_done <= 1'b1;
            r_busy       <= 1'b0;
            r_state      <= S_IDLE;
          end
        end
        default: begin
          r_inflight <= 1'b0;
          r_busy     <= 1'b0;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_fetcher.sv
// Directed bench for frame_fetcher: three instances (4, 16 and 1200 word frames) share a
// combinational RAM model; a scoreboard queue holds the words each started frame must deliver.
module tb_frame_fetcher;

  localparam int NI = 3;

  typedef struct {
    logic [15:0] d;
    logic        l;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_s [NI];
  logic [15:0] base_s  [NI];
  logic [15:0] addr_s  [NI];
  logic [15:0] outb_s  [NI];
  logic [15:0] data_s  [NI];
  logic        valid_s [NI];
  logic        ready_s [NI];
  logic        last_s  [NI];
  logic        busy_s  [NI];
  logic        done_s  [NI];

  exp_t sb[$];
  int   done_cnt [NI];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  function automatic int fw_of(input int i);
    return (i == 0) ? 4 : ((i == 1) ? 16 : 1200);
  endfunction

  function automatic logic [15:0] ram_f(input logic [15:0] a);
    if (a >= 16'h0100 && a <= 16'h0103) return 16'h00A1 + (a - 16'h0100);
    else return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  always_comb begin
    for (int i = 0; i < NI; i++) outb_s[i] = ram_f(addr_s[i]);
  end

  for (genvar g = 0; g < NI; g++) begin : g_dut
    frame_fetcher #(
      .FRAME_WORDS((g == 0) ? 4 : ((g == 1) ? 16 : 1200)),
      .FIFO_DEPTH (8),
      .RD_LATENCY (1)
    ) u_dut (
      .clk       (clk),
      .reset     (rst_n),
      .start     (start_s[g]),
      .base_addr (base_s[g]),
      .addr_B    (addr_s[g]),
      .out_B     (outb_s[g]),
      .word_data (data_s[g]),
      .word_valid(valid_s[g]),
      .word_ready(ready_s[g]),
      .word_last (last_s[g]),
      .busy      (busy_s[g]),
      .frame_done(done_s[g])
    );
  end

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Pops are decided at the next rising edge, so sample handshakes on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < NI; i++) begin
      if (rst_n && done_s[i]) done_cnt[i]++;
      if (rst_n && valid_s[i] && ready_s[i]) begin
        if (sb.size() == 0) begin
          chki("unexpected_word", 1, 0);
        end else begin
          e = sb.pop_front();
          chk16("word_data", data_s[i], e.d);
          chk1("word_last", last_s[i], e.l);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input int i, input logic [15:0] base);
    exp_t e;
    for (int w = 0; w < fw_of(i); w++) begin
      e.d = ram_f(base + 16'(w));
      e.l = (w == fw_of(i) - 1);
      sb.push_back(e);
    end
    base_s[i]  = base;
    start_s[i] = 1'b1;
    tick(1);
    start_s[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, input int budget, input string tag);
    int n = 0;
    while (!done_s[i] && n < budget) begin
      tick(1);
      n++;
    end
    chk1(tag, done_s[i], 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int bad;
    int n;
    rst_n = 1'b0;
    for (int i = 0; i < NI; i++) begin
      start_s[i] = 1'b0; base_s[i] = 16'h0000; ready_s[i] = 1'b0; done_cnt[i] = 0;
    end
    tick(3);
    for (int i = 0; i < NI; i++) begin
      chk16("rst_addr", addr_s[i], 16'h0000);
      chk1("rst_valid", valid_s[i], 1'b0);
      chk1("rst_busy", busy_s[i], 1'b0);
      chk1("rst_done", done_s[i], 1'b0);
      chk1("rst_last", last_s[i], 1'b0);
    end
    rst_n = 1'b1;
    tick(2);

    // Reset held 3 cycles mid-FETCH on the 1200-word instance
    start_frame(2, 16'h0200);
    tick(5);
    chk1("midfetch_busy", busy_s[2], 1'b1);
    rst_n = 1'b0;
    #1;
    chk16("async_rst_addr", addr_s[2], 16'h0000);
    chk1("async_rst_valid", valid_s[2], 1'b0);
    tick(3);
    sb.delete();
    rst_n = 1'b1;
    tick(3);
    chk1("idle_busy", busy_s[2], 1'b0);
    chk1("idle_valid", valid_s[2], 1'b0);
    chk16("idle_addr", addr_s[2], 16'h0000);
    chki("idle_no_done", done_cnt[2], 0);

    // Basic 4-word frame with cycle-exact addresses and frame_done timing
    ready_s[0] = 1'b1;
    start_frame(0, 16'h0100);
    chk1("basic_busy", busy_s[0], 1'b1);
    tick(1); chk16("basic_addr0", addr_s[0], 16'h0100);
    chk1("basic_valid_early", valid_s[0], 1'b0);
    tick(1); chk16("basic_addr1", addr_s[0], 16'h0101);
    chk1("basic_valid", valid_s[0], 1'b1);
    chk16("basic_head", data_s[0], 16'h00A1);
    tick(1); chk16("basic_addr2", addr_s[0], 16'h0102);
    tick(1); chk16("basic_addr3", addr_s[0], 16'h0103);
    tick(1); chk1("basic_last_a4", last_s[0], 1'b1);
    chk1("basic_done_early", done_s[0], 1'b0);
    tick(1); chk1("basic_done", done_s[0], 1'b1);
    chk1("basic_busy_clr", busy_s[0], 1'b0);
    chk1("basic_empty", valid_s[0], 1'b0);
    tick(1); chk1("basic_done_pulse", done_s[0], 1'b0);
    chki("basic_done_cnt", done_cnt[0], 1);
    chki("basic_sb_empty", sb.size(), 0);

    // Backpressure: 16-word frame stalls after exactly 8 issues
    ready_s[1] = 1'b0;
    start_frame(1, 16'h0300);
    tick(12);
    chk16("bp_addr_stall", addr_s[1], 16'h0307);
    chk1("bp_valid", valid_s[1], 1'b1);
    tick(3);
    chk16("bp_addr_frozen", addr_s[1], 16'h0307);
    ready_s[1] = 1'b1;
    wait_done(1, 60, "bp_done");
    tick(1);
    chki("bp_sb_empty", sb.size(), 0);
    chki("bp_done_cnt", done_cnt[1], 1);

    // Throttled ready toggling every cycle
    d0 = done_cnt[1];
    bad = 0;
    n = 0;
    ready_s[1] = 1'b1;
    start_frame(1, 16'h0500);
    while (!done_s[1] && n < 120) begin
      if (!busy_s[1]) bad++;
      ready_s[1] = ~ready_s[1];
      tick(1);
      n++;
    end
    chk1("thr_done", done_s[1], 1'b1);
    chki("thr_busy_held", bad, 0);
    ready_s[1] = 1'b1;
    tick(2);
    chki("thr_done_cnt", done_cnt[1] - d0, 1);
    chki("thr_sb_empty", sb.size(), 0);

    // Address wrap with an ignored mid-frame start
    start_frame(0, 16'hFFFE);
    tick(1); chk16("wrap_addr0", addr_s[0], 16'hFFFE);
    base_s[0] = 16'h1234;
    start_s[0] = 1'b1;
    tick(1); chk16("wrap_addr1", addr_s[0], 16'hFFFF);
    start_s[0] = 1'b0;
    tick(1); chk16("wrap_addr2", addr_s[0], 16'h0000);
    tick(1); chk16("wrap_addr3", addr_s[0], 16'h0001);
    wait_done(0, 10, "wrap_done");
    tick(2);
    chk1("wrap_no_restart", busy_s[0], 1'b0);
    chki("wrap_sb_empty", sb.size(), 0);
    chki("wrap_done_cnt", done_cnt[0], 2);

    // Abort a 1200-word frame after 3 pops, then run a full frame from base 0
    ready_s[2] = 1'b1;
    start_frame(2, 16'h0800);
    tick(5);
    chki("abort_pops", sb.size(), 1200 - 3);
    rst_n = 1'b0;
    #1;
    chk1("abort_valid", valid_s[2], 1'b0);
    chk1("abort_busy", busy_s[2], 1'b0);
    sb.delete();
    tick(3);
    rst_n = 1'b1;
    tick(2);
    chki("abort_no_done", done_cnt[2], 0);
    start_frame(2, 16'h0000);
    tick(1); chk16("restart_addr0", addr_s[2], 16'h0000);
    tick(1); chk16("restart_addr1", addr_s[2], 16'h0001);
    wait_done(2, 1300, "full_done");
    tick(1);
    chki("full_sb_empty", sb.size(), 0);
    chki("full_done_cnt", done_cnt[2], 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
